// File: rtl/irq_priority_ctrl_if.sv
// CPU-side bus of irq_priority_ctrl: request lines, mask/enable controls and the
// req/ack/eret handshake, plus the pending and in-service status.
interface irq_priority_ctrl_if #(
  parameter int NUM_IRQ  = 3,
  parameter int ID_WIDTH = 2
);
  logic [NUM_IRQ-1:0]  irq_in;
  logic                int_en;
  logic                mask_we;
  logic [NUM_IRQ-1:0]  mask_wdata;
  logic                int_ack;
  logic                int_eret;
  logic                int_req;
  logic [ID_WIDTH-1:0] int_id;
  logic [NUM_IRQ-1:0]  pending;
  logic [NUM_IRQ-1:0]  irw;

  modport master (
    output irq_in, int_en, mask_we, mask_wdata, int_ack, int_eret,
    input  int_req, int_id, pending, irw
  );

  modport slave (
    input  irq_in, int_en, mask_we, mask_wdata, int_ack, int_eret,
    output int_req, int_id, pending, irw
  );
endinterface

// File: rtl/irq_priority_ctrl.sv
// Fixed-priority nesting interrupt controller (higher index wins) with a
// req/ack/eret CPU handshake. Optional input debounce under IRQ_DEBOUNCE_EN.
module irq_priority_ctrl #(
  parameter int NUM_IRQ  = 3,
  parameter int ID_WIDTH = 2
`ifdef IRQ_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  irq_priority_ctrl_if.slave   bus
);

  logic [NUM_IRQ-1:0]  s1_r, s2_r, s3_r;
  logic [NUM_IRQ-1:0]  filt_s, rise_s;
  logic [NUM_IRQ-1:0]  chan_en_r, pending_r, irw_r;
  logic [NUM_IRQ-1:0]  pending_nxt_s, irw_nxt_s, cand_s, ack_mask_s, eret_mask_s;
  logic                int_req_r, int_req_nxt_s, ack_ok_s;
  logic [ID_WIDTH-1:0] int_id_r, top_s, cur_s;

  function automatic logic [ID_WIDTH-1:0] msb_idx(input logic [NUM_IRQ-1:0] v);
    msb_idx = {ID_WIDTH{1'b0}};
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (v[i]) msb_idx = ID_WIDTH'(i);
    end
  endfunction

  function automatic logic [NUM_IRQ-1:0] msb_onehot(input logic [NUM_IRQ-1:0] v);
    msb_onehot = {NUM_IRQ{1'b0}};
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (v[i]) begin
        msb_onehot    = {NUM_IRQ{1'b0}};
        msb_onehot[i] = 1'b1;
      end
    end
  endfunction

  function automatic logic [NUM_IRQ-1:0] id_onehot(input logic [ID_WIDTH-1:0] id);
    for (int i = 0; i < NUM_IRQ; i++) begin
      id_onehot[i] = (id == ID_WIDTH'(i));
    end
  endfunction

`ifdef IRQ_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0]   cnt_r [NUM_IRQ];
  logic [NUM_IRQ-1:0] filt_r;

  // Per-channel stability filter: f follows s2 only after a full run of differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_r <= {NUM_IRQ{1'b0}};
      for (int i = 0; i < NUM_IRQ; i++) cnt_r[i] <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (s2_r[i] == filt_r[i]) begin
          cnt_r[i] <= {CNT_W{1'b0}};
        end else if (cnt_r[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          filt_r[i] <= s2_r[i];
          cnt_r[i]  <= {CNT_W{1'b0}};
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  assign filt_s = filt_r;
`else
  assign filt_s = s2_r;
`endif

  assign rise_s = filt_s & ~s3_r;

  // Arbitration, handshake decode and next-state for pending / in-service
  always_comb begin
    ack_ok_s    = bus.int_ack & int_req_r;
    cand_s      = pending_r & chan_en_r;
    top_s       = msb_idx(cand_s);
    cur_s       = msb_idx(irw_r);
    ack_mask_s  = ack_ok_s     ? id_onehot(int_id_r) : {NUM_IRQ{1'b0}};
    // msb_onehot of an empty irw is zero, so an eret with nothing in service is a no-op
    eret_mask_s = bus.int_eret ? msb_onehot(irw_r)   : {NUM_IRQ{1'b0}};
    pending_nxt_s = (pending_r & ~ack_mask_s) | rise_s;
    irw_nxt_s     = (irw_r & ~eret_mask_s) | ack_mask_s;
    if (ack_ok_s) begin
      int_req_nxt_s = 1'b0;
    end else begin
      int_req_nxt_s = bus.int_en & (|cand_s) & (~(|irw_r) | (top_s > cur_s));
    end
  end

  // Synchroniser, edge history, channel enables and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r      <= {NUM_IRQ{1'b0}};
      s2_r      <= {NUM_IRQ{1'b0}};
      s3_r      <= {NUM_IRQ{1'b0}};
      chan_en_r <= {NUM_IRQ{1'b1}};
      pending_r <= {NUM_IRQ{1'b0}};
      irw_r     <= {NUM_IRQ{1'b0}};
      int_req_r <= 1'b0;
      int_id_r  <= {ID_WIDTH{1'b0}};
    end else begin
      s1_r      <= bus.irq_in;
      s2_r      <= s1_r;
      s3_r      <= filt_s;
      chan_en_r <= bus.mask_we ? bus.mask_wdata : chan_en_r;
      pending_r <= pending_nxt_s;
      irw_r     <= irw_nxt_s;
      int_req_r <= int_req_nxt_s;
      int_id_r  <= top_s;
    end
  end

  assign bus.int_req = int_req_r;
  assign bus.int_id  = int_id_r;
  assign bus.pending = pending_r;
  assign bus.irw     = irw_r;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Self-checking bench for irq_priority_ctrl (default build): directed scenarios
// plus randomized traffic against a stack-based reference model.
module tb_irq_priority_ctrl;
  localparam int N = 3;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  irq_priority_ctrl_if #(.NUM_IRQ(N), .ID_WIDTH(W)) bus ();
  irq_priority_ctrl #(.NUM_IRQ(N), .ID_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: pending bits, enable mask, a stack of channels in service,
  // and the raw input samples taken at each clock edge (newest first).
  logic [N-1:0] m_pend, m_en;
  int           m_stack[$];
  logic [N-1:0] hist[$];
  logic         m_req;
  int           m_id;

  task automatic model_reset();
    m_pend = '0; m_en = '1; m_req = 1'b0; m_id = 0;
    m_stack.delete();
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back('0);
  endtask

  function automatic logic [N-1:0] model_irw();
    logic [N-1:0] v = '0;
    foreach (m_stack[k]) v[m_stack[k]] = 1'b1;
    return v;
  endfunction

  task automatic model_update();
    logic [N-1:0] rise;
    int top, cur;
    bit ack_ok, nreq;
    rise = hist[1] & ~hist[2];  // level two edges ago high, three edges ago low
    top = -1;
    for (int i = 0; i < N; i++) if (m_pend[i] && m_en[i]) top = i;
    cur = (m_stack.size() > 0) ? m_stack[$] : -1;
    ack_ok = bus.int_ack && m_req;
    nreq = !ack_ok && bus.int_en && (top >= 0) && (top > cur);
    if (ack_ok) m_pend[m_id] = 1'b0;
    m_pend = m_pend | rise;
    if (bus.int_eret && m_stack.size() > 0) void'(m_stack.pop_back());
    if (ack_ok) m_stack.push_back(m_id);
    if (bus.mask_we) m_en = bus.mask_wdata;
    m_req = nreq;
    m_id = (top < 0) ? 0 : top;
    hist.push_front(bus.irq_in);
    void'(hist.pop_back());
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [8:0] got, exp;
    bus.irq_in = '0; bus.int_en = 1'b1; bus.mask_we = 1'b0; bus.mask_wdata = '0;
    bus.int_ack = 1'b0; bus.int_eret = 1'b0;
    model_reset();
    #2;
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw}; exp = 9'b0_00_000_000;
    checks++; if (got !== exp) begin errors++; $display("FAIL reset: got %b expected %b", got, exp); end
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [8:0] got;
    logic [8:0] exp[4] = '{9'b0_00_010_000, 9'b1_01_010_000, 9'b0_01_000_010, 9'b0_00_000_000};
    bus.irq_in = 3'b010; step(); step(); step();
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[0]) begin errors++; $display("FAIL single_pend: got %b expected %b", got, exp[0]); end
    step();
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[1]) begin errors++; $display("FAIL single_req: got %b expected %b", got, exp[1]); end
    bus.irq_in = 3'b000; bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[2]) begin errors++; $display("FAIL single_ack: got %b expected %b", got, exp[2]); end
    bus.int_eret = 1'b1; step(); bus.int_eret = 1'b0;
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[3]) begin errors++; $display("FAIL single_eret: got %b expected %b", got, exp[3]); end
  endtask

  task automatic test_simultaneous();
    logic [8:0] got;
    logic [8:0] exp[5] = '{9'b1_10_101_000, 9'b0_10_001_100, 9'b0_00_001_100,
                           9'b0_00_001_000, 9'b1_00_001_000};
    bus.irq_in = 3'b101; step(); step(); bus.irq_in = 3'b000; step(); step();
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[0]) begin errors++; $display("FAIL simul_req: got %b expected %b", got, exp[0]); end
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[1]) begin errors++; $display("FAIL simul_ack: got %b expected %b", got, exp[1]); end
    step();
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[2]) begin errors++; $display("FAIL simul_lower_blocked: got %b expected %b", got, exp[2]); end
    bus.int_eret = 1'b1; step(); bus.int_eret = 1'b0;
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[3]) begin errors++; $display("FAIL simul_eret: got %b expected %b", got, exp[3]); end
    step();
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[4]) begin errors++; $display("FAIL simul_ch0_req: got %b expected %b", got, exp[4]); end
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;  // ch0 now in service
  endtask

  task automatic test_nesting();
    logic [8:0] got;
    logic [8:0] exp[5] = '{9'b0_00_000_001, 9'b1_10_100_001, 9'b0_10_000_101,
                           9'b0_00_000_001, 9'b0_00_000_000};
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[0]) begin errors++; $display("FAIL nest_start: got %b expected %b", got, exp[0]); end
    bus.irq_in = 3'b100; step(); step(); bus.irq_in = 3'b000; step(); step();
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[1]) begin errors++; $display("FAIL nest_preempt_req: got %b expected %b", got, exp[1]); end
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[2]) begin errors++; $display("FAIL nest_ack: got %b expected %b", got, exp[2]); end
    bus.int_eret = 1'b1; step();
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[3]) begin errors++; $display("FAIL nest_eret1: got %b expected %b", got, exp[3]); end
    step(); bus.int_eret = 1'b0;
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[4]) begin errors++; $display("FAIL nest_eret2: got %b expected %b", got, exp[4]); end
  endtask

  task automatic test_masking();
    logic [8:0] got;
    logic [8:0] exp[5] = '{9'b0_00_100_000, 9'b1_10_100_000, 9'b0_10_100_000,
                           9'b0_10_100_000, 9'b1_10_100_000};
    bus.mask_we = 1'b1; bus.mask_wdata = 3'b011; step(); bus.mask_we = 1'b0;
    bus.irq_in = 3'b100; step(); step(); bus.irq_in = 3'b000; step(); step();
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[0]) begin errors++; $display("FAIL mask_blocked: got %b expected %b", got, exp[0]); end
    bus.mask_we = 1'b1; bus.mask_wdata = 3'b111; step(); bus.mask_we = 1'b0; step();
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[1]) begin errors++; $display("FAIL mask_unmask_req: got %b expected %b", got, exp[1]); end
    bus.int_en = 1'b0; step();
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[2]) begin errors++; $display("FAIL mask_int_en_off: got %b expected %b", got, exp[2]); end
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[3]) begin errors++; $display("FAIL ack_without_req: got %b expected %b", got, exp[3]); end
    bus.int_en = 1'b1; step();
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[4]) begin errors++; $display("FAIL mask_int_en_on: got %b expected %b", got, exp[4]); end
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
    bus.int_eret = 1'b1; step(); bus.int_eret = 1'b0;
  endtask

  task automatic test_ack_rise_same_cycle();
    logic [8:0] got;
    logic [8:0] exp[3] = '{9'b1_01_010_000, 9'b0_01_010_010, 9'b0_01_010_010};
    bus.irq_in = 3'b010; step(); bus.irq_in = 3'b000; step(); step();
    bus.irq_in = 3'b010; step();
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[0]) begin errors++; $display("FAIL race_req: got %b expected %b", got, exp[0]); end
    step(); bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[1]) begin errors++; $display("FAIL race_rise_wins: got %b expected %b", got, exp[1]); end
    step();
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[2]) begin errors++; $display("FAIL race_same_prio_waits: got %b expected %b", got, exp[2]); end
    bus.irq_in = 3'b000;
    bus.int_eret = 1'b1; step(); bus.int_eret = 1'b0; step();
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
    bus.int_eret = 1'b1; step(); bus.int_eret = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [8:0] got;
    logic [8:0] exp[5] = '{9'b0_00_001_100, 9'b0_00_000_000, 9'b0_00_101_000,
                           9'b1_10_101_000, 9'b0_00_001_100};
    bus.irq_in = 3'b100; step(); step(); step(); step();
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
    bus.irq_in = 3'b101; step(); step(); step();
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[0]) begin errors++; $display("FAIL arst_before: got %b expected %b", got, exp[0]); end
    #2 rst = 1'b1; model_reset(); #1;
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[1]) begin errors++; $display("FAIL arst_immediate: got %b expected %b", got, exp[1]); end
    step(); rst = 1'b0;
    step(); step(); step();  // irq_in held high through reset
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[2]) begin errors++; $display("FAIL arst_held_line_edge: got %b expected %b", got, exp[2]); end
    step();
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[3]) begin errors++; $display("FAIL arst_after_req: got %b expected %b", got, exp[3]); end
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0; step();
    got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
    checks++; if (got !== exp[4]) begin errors++; $display("FAIL arst_single_edge: got %b expected %b", got, exp[4]); end
    bus.irq_in = 3'b000;
    bus.int_eret = 1'b1; step(); bus.int_eret = 1'b0; step();
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
    bus.int_eret = 1'b1; step(); bus.int_eret = 1'b0;
  endtask

  task automatic test_random();
    logic [8:0] got, exp;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) bus.irq_in[i] = ~bus.irq_in[i];
      bus.int_en     = ($urandom_range(0, 9) != 0);
      bus.mask_we    = ($urandom_range(0, 19) == 0);
      bus.mask_wdata = N'($urandom);
      bus.int_ack    = ($urandom_range(0, 2) == 0);
      bus.int_eret   = ($urandom_range(0, 4) == 0);
      step();
      got = {bus.int_req, bus.int_id, bus.pending, bus.irw};
      exp = {m_req, W'(m_id), m_pend, model_irw()};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle%0d: got %b expected %b", c, got, exp);
      end
    end
    bus.int_ack = 1'b0; bus.int_eret = 1'b0; bus.mask_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_nesting();
    test_masking();
    test_ack_rise_same_cycle();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
